serial_paralelo_rx: RTL and testbench
=====================================

SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 The block SHALL have parameter COM, default 8'hBC, the alignment/comma symbol.
REQ-002 The block SHALL have parameter IDLE, default 8'h7C, the idle filler symbol.
REQ-003 The block SHALL have parameter COM_REQ, default 4, the number of consecutive aligned COM bytes required to go active.
REQ-004 The block SHALL have port clk_32f, input, 1, the serial bit clock; one clock only, with all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-006 The block SHALL have port data_in, input, 1, the serial lane bit, MSB of each byte first.
REQ-007 The block SHALL have port data_out, output, 8, the recovered byte.
REQ-008 The block SHALL have port valid_out, output, 1, high while data_out holds a data byte.
REQ-009 The block SHALL have port active, output, 1, high once lane alignment is achieved.

Function
REQ-010 The block SHALL sample data_in on every rising clk_32f edge into an 8-bit shift register, forming window = {sr[6:0], data_in}.
REQ-011 The block SHALL implement FSM states SEARCH, ALIGN and ACTIVE.
REQ-012 In SEARCH, on an edge where window == COM, the block SHALL set bit_cnt=0, com_cnt=1 and move to ALIGN; otherwise it SHALL remain in SEARCH (bit-granular sliding search).
REQ-013 In ALIGN and ACTIVE, bit_cnt SHALL increment every edge, and its wrap 7->0 SHALL define a byte boundary, where window is the complete byte.
REQ-014 At an ALIGN boundary where byte == COM, com_cnt SHALL increment; on reaching COM_REQ, the FSM SHALL go to ACTIVE.
REQ-015 At an ALIGN boundary where byte != COM, the block SHALL return to SEARCH with com_cnt=0, and the same window SHALL NOT be re-tested as COM on that edge.
REQ-016 At an ACTIVE boundary where byte is neither COM nor IDLE, the block SHALL register data_out=byte and valid_out=1.
REQ-017 At an ACTIVE boundary where byte is COM or IDLE, the block SHALL set valid_out=0 and data_out SHALL hold its previous value.
REQ-018 data_out and valid_out SHALL be held for exactly 8 clk_32f cycles, until the next boundary, so that a clk_4f consumer samples each byte once.
REQ-019 Latency SHALL be 1 clk_32f cycle from sampling the byte's last bit (LSB) to the corresponding data_out/valid_out update.
REQ-020 active SHALL be registered high on the edge the FSM enters ACTIVE, and SHALL stay high until reset.
REQ-021 ACTIVE SHALL have no exit other than reset; COM bytes received while ACTIVE SHALL be discarded.
REQ-022 com_cnt SHALL saturate at COM_REQ and be 3 bits wide for the default value.

Reset
REQ-023 While reset is high, the block SHALL force state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0 and active=0, asynchronously.
REQ-024 Reset asserted mid-byte or mid-ALIGN SHALL discard any partial byte, and after release, detection SHALL restart from SEARCH with no stale valid_out.
REQ-025 The first sample after reset release SHALL be taken on the first rising edge with reset low.

Structure
REQ-026 COM, IDLE, COM_REQ defaults and the FSM state encoding (2 bits: SEARCH=0, ALIGN=1, ACTIVE=2) SHALL live in the shared phy_pkg, also used by the transmit-side paralelo_serial.
REQ-027 The shift register plus bit counter SHALL be one natural sub-module, rx_byte_framer, with outputs window and boundary; the FSM and output registers SHALL sit in serial_paralelo_rx.

Verification
REQ-028 Reset, then 4x 8'hBC serial -> active=1 one cycle after the 32nd bit, with valid_out=0 throughout.
REQ-029 The same stream preceded by 3 random bits (offset alignment) -> active=1 after the 4th COM, and subsequent 8'hA5 -> data_out=8'hA5 with valid_out=1 for 8 cycles.
REQ-030 A stream of 8'hBC, 8'hBC, 8'h3C, then 4x 8'hBC -> return to SEARCH at the 3rd byte, with active asserted only after the final 4 COMs.
REQ-031 In ACTIVE, the sequence 8'h12, 8'h7C, 8'hBC, 8'h34 -> valid_out pattern 1,0,0,1 per byte with data_out 12,12,12,34.
REQ-032 Reset asserted at bit 5 of data byte 8'hF0 while ACTIVE -> all outputs 0 immediately, and a re-sync is required before valid_out=1 again.
REQ-033 Continuous 8'h7C after alignment -> active stays 1 and valid_out stays 0 indefinitely.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared lane-protocol definitions for the serial PHY: control symbols,
// alignment threshold and the receive FSM encoding.
package phy_pkg;

  localparam logic [7:0] COM_DEF     = 8'hBC;
  localparam logic [7:0] IDLE_DEF    = 8'h7C;
  localparam int         COM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  // Control symbols never reach the parallel data path.
  function automatic logic is_ctrl_sym(input logic [7:0] sym,
                                       input logic [7:0] com,
                                       input logic [7:0] idle);
    return (sym == com) || (sym == idle);
  endfunction

endpackage

// File: rtl/rx_byte_framer.sv
// Serial-to-window shifter plus bit counter that marks byte boundaries once
// the lane has been locked onto a COM symbol.
module rx_byte_framer (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       restart_i,
  input  logic       count_en_i,
  output logic [7:0] window_o,
  output logic       boundary_o
);

  // Seven stored bits suffice: the window's LSB is always the live input.
  logic [6:0] hist_q;
  logic [2:0] bit_cnt_q;

  assign window_o   = {hist_q, data_in};
  assign boundary_o = count_en_i && (bit_cnt_q == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      hist_q <= window_o[6:0];
      if (restart_i) begin
        bit_cnt_q <= '0;
      end else if (count_en_i) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial lane receiver: sliding COM search, COM_REQ-deep alignment check, then
// byte recovery with control symbols stripped from the parallel output.
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter logic [7:0] COM     = COM_DEF,
  parameter logic [7:0] IDLE    = IDLE_DEF,
  parameter int         COM_REQ = COM_REQ_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int               CNT_W     = $clog2(COM_REQ + 1);
  localparam logic [CNT_W-1:0] COM_REQ_C = CNT_W'(COM_REQ);

  rx_state_e        state_q;
  logic [CNT_W-1:0] com_cnt_q;
  logic [7:0]       data_out_q;
  logic             valid_q;
  logic             active_q;

  logic [7:0] window;
  logic       boundary;
  logic       com_hit;
  logic       restart;

  assign com_hit = (window == COM);
  assign restart = (state_q == SEARCH) && com_hit;

  rx_byte_framer u_framer (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .restart_i  (restart),
    .count_en_i (state_q != SEARCH),
    .window_o   (window),
    .boundary_o (boundary)
  );

  // NOTE: every branch below either assigns a register or lets it hold; in a
  // clocked block that is a plain enable, never a latch.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      com_cnt_q  <= '0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          valid_q <= 1'b0;
          if (com_hit) begin
            com_cnt_q <= CNT_W'(1);
            if (COM_REQ <= 1) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q <= ALIGN;
            end
          end
        end

        ALIGN: begin
          valid_q <= 1'b0;
          if (boundary) begin
            if (!com_hit) begin
              // Lost lock: resume the bit-granular search on the next edge.
              state_q   <= SEARCH;
              com_cnt_q <= '0;
            end else if (com_cnt_q >= COM_REQ_C - CNT_W'(1)) begin
              com_cnt_q <= COM_REQ_C;
              state_q   <= ACTIVE;
              active_q  <= 1'b1;
            end else begin
              com_cnt_q <= com_cnt_q + CNT_W'(1);
            end
          end
        end

        ACTIVE: begin
          // Outputs change only at boundaries, so each byte is held 8 bit times.
          if (boundary) begin
            if (is_ctrl_sym(window, COM, IDLE)) begin
              valid_q <= 1'b0;
            end else begin
              data_out_q <= window;
              valid_q    <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= SEARCH;
          com_cnt_q <= '0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: alignment, offset search,
// lost-lock recovery, control stripping, byte hold and asynchronous reset.
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] byte_in;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb_q[$];
  logic       hold_v;
  logic [7:0] hold_d;

  serial_paralelo_rx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called and returns at a falling edge; the bit is sampled on the rising edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    @(negedge clk_32f);
  endtask

  task automatic send_quiet(input logic [7:0] b, input logic exp_act);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      check("quiet_valid", valid_out, 1'b0);
    end
    check("quiet_active", active, exp_act);
  endtask

  // Four COMs from SEARCH; active must rise exactly on the 32nd bit.
  task automatic align4();
    logic [7:0] com;
    com = 8'hBC;
    for (int k = 0; k < 3; k++) send_quiet(com, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    check("active_before_32nd", active, 1'b0);
    send_bit(com[0]);
    check("active_after_32nd", active, 1'b1);
    check("valid_at_lock", valid_out, 1'b0);
  endtask

  task automatic send_active(input logic [7:0] b, input logic ev, input logic [7:0] ed);
    exp_t e;
    exp_t got;
    e.v = ev;
    e.d = ed;
    sb_q.push_back(e);
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      check("hold_valid", valid_out, hold_v);
      check("hold_data", data_out, hold_d);
    end
    send_bit(b[0]);
    got = sb_q.pop_front();
    check("byte_valid", valid_out, got.v);
    check("byte_data", data_out, got.d);
    check("active_held", active, 1'b1);
    hold_v = got.v;
    hold_d = got.d;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 1'b0);
    check("rst_active", active, 1'b0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    sb_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0] f0;
    logic [2:0] rnd;

    vecs[0] = '{8'h12, 1'b1, 8'h12};
    vecs[1] = '{8'h7C, 1'b0, 8'h12};
    vecs[2] = '{8'hBC, 1'b0, 8'h12};
    vecs[3] = '{8'h34, 1'b1, 8'h34};
    vecs[4] = '{8'h00, 1'b1, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF};
    vecs[6] = '{8'h3C, 1'b1, 8'h3C};
    vecs[7] = '{8'h7C, 1'b0, 8'h3C};
    vecs[8] = '{8'h5A, 1'b1, 8'h5A};

    reset   = 1'b1;
    data_in = 1'b0;
    @(negedge clk_32f);
    do_reset();

    // Aligned COM stream straight after reset.
    align4();
    hold_v = 1'b0;
    hold_d = 8'h00;

    // Data and control bytes while active.
    foreach (vecs[i]) send_active(vecs[i].byte_in, vecs[i].exp_valid, vecs[i].exp_data);

    // Continuous IDLE keeps the lane active with no valid bytes.
    for (int k = 0; k < 6; k++) send_active(8'h7C, 1'b0, 8'h5A);

    // Give valid_out a 1 to clear, then reset at bit 5 of a data byte.
    send_active(8'hC3, 1'b1, 8'hC3);
    f0 = 8'hF0;
    for (int i = 7; i >= 3; i--) send_bit(f0[i]);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_data", data_out, 8'h00);
    check("async_rst_valid", valid_out, 1'b0);
    check("async_rst_active", active, 1'b0);
    @(negedge clk_32f);
    reset = 1'b0;
    send_quiet(8'hA5, 1'b0);
    send_quiet(8'hA5, 1'b0);
    align4();
    hold_v = 1'b0;
    hold_d = 8'h00;
    send_active(8'hA5, 1'b1, 8'hA5);

    // Offset alignment: three random bits ahead of the COM stream.
    do_reset();
    rnd = 3'($urandom);
    for (int i = 2; i >= 0; i--) send_bit(rnd[i]);
    align4();
    hold_v = 1'b0;
    hold_d = 8'h00;
    send_active(8'hA5, 1'b1, 8'hA5);
    send_active(8'h7C, 1'b0, 8'hA5);

    // Broken alignment: third byte is not COM, so four fresh COMs are needed.
    do_reset();
    send_quiet(8'hBC, 1'b0);
    send_quiet(8'hBC, 1'b0);
    send_quiet(8'h3C, 1'b0);
    align4();
    hold_v = 1'b0;
    hold_d = 8'h00;
    send_active(8'h66, 1'b1, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
